// File: rtl/fb_rect_fill.sv
// fb_rect_fill: clipped rectangle fill emitting one {x,y} RAM write per clock in raster order.
// Define FILL_VBLANK_ONLY_EN to restrict writes to vblank cycles.
module fb_rect_fill #(
  parameter int H_RES   = 640,
  parameter int V_RES   = 480,
  parameter int COLOR_W = 12
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [9:0]         cmd_x0,
  input  logic [8:0]         cmd_y0,
  input  logic [9:0]         cmd_w,
  input  logic [8:0]         cmd_h,
  input  logic [COLOR_W-1:0] cmd_color,
  input  logic               vblank,
  output logic               wr_en,
  output logic [18:0]        wr_addr,
  output logic [COLOR_W-1:0] wr_data,
  output logic               busy,
  output logic               done
);
  typedef enum logic [1:0] {IDLE, CLIP, FILL, DONE} state_t;
  localparam logic [10:0] HL = 11'(H_RES);
  localparam logic [9:0]  VL = 10'(V_RES);
  state_t state_q, state_d;
  logic [9:0] x0_q, x0_d, w_q, w_d, x_q, x_d;
  logic [8:0] y0_q, y0_d, h_q, h_d, y_q, y_d;
  logic [10:0] x_end_q, x_end_d, x_sum;
  logic [9:0] y_end_q, y_end_d, y_sum;
  logic [COLOR_W-1:0] col_q, col_d, data_q, data_d;
  logic gate, noop, last_x, last_y, step;
`ifdef FILL_VBLANK_ONLY_EN
  assign gate = vblank;
`else
  logic vblank_unused;
  assign vblank_unused = vblank;
  assign gate = 1'b1;
`endif
  assign x_sum  = {1'b0, x0_q} + {1'b0, w_q};
  assign y_sum  = {1'b0, y0_q} + {1'b0, h_q};
  assign noop   = w_q == '0 || h_q == '0 || {1'b0, x0_q} >= HL || {1'b0, y0_q} >= VL;
  assign last_x = {1'b0, x_q} == x_end_q - 11'd1;
  assign last_y = {1'b0, y_q} == y_end_q - 10'd1;
  assign step   = state_q == FILL && gate;
  assign cmd_ready = state_q == IDLE && !reset;
  assign busy    = state_q != IDLE;
  assign done    = state_q == DONE;
  assign wr_en   = step;
  assign wr_addr = {x_q, y_q};
  assign wr_data = data_q;
  always_comb begin
    state_d = state_q;
    x0_d = x0_q;
    y0_d = y0_q;
    w_d = w_q;
    h_d = h_q;
    col_d = col_q;
    x_d = x_q;
    y_d = y_q;
    x_end_d = x_end_q;
    y_end_d = y_end_q;
    data_d = data_q;
    case (state_q)
      IDLE: if (cmd_valid) begin
        x0_d = cmd_x0;
        y0_d = cmd_y0;
        w_d = cmd_w;
        h_d = cmd_h;
        col_d = cmd_color;
        state_d = CLIP;
      end
      CLIP: begin
        x_end_d = x_sum > HL ? HL : x_sum;
        y_end_d = y_sum > VL ? VL : y_sum;
        state_d = noop ? DONE : FILL;
        if (!noop) begin
          x_d = x0_q;
          y_d = y0_q;
          data_d = col_q;
        end
      end
      FILL: if (step) begin
        // x/y stay on the final pixel so the address holds after the fill
        state_d = last_x && last_y ? DONE : FILL;
        x_d = last_x ? (last_y ? x_q : x0_q) : x_q + 10'd1;
        y_d = last_x && !last_y ? y_q + 9'd1 : y_q;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      x0_q <= '0;
      y0_q <= '0;
      w_q <= '0;
      h_q <= '0;
      col_q <= '0;
      x_q <= '0;
      y_q <= '0;
      x_end_q <= '0;
      y_end_q <= '0;
      data_q <= '0;
    end else begin
      state_q <= state_d;
      x0_q <= x0_d;
      y0_q <= y0_d;
      w_q <= w_d;
      h_q <= h_d;
      col_q <= col_d;
      x_q <= x_d;
      y_q <= y_d;
      x_end_q <= x_end_d;
      y_end_q <= y_end_d;
      data_q <= data_d;
    end
  end
endmodule

// File: tb/tb_fb_rect_fill.sv
// tb_fb_rect_fill: table vectors, corner sequences and random commands against a pixel-list model.
module tb_fb_rect_fill;
  logic clk = 1'b0, reset = 1'b1, cmd_valid = 1'b0, vblank = 1'b1;
  logic [9:0] cmd_x0 = '0, cmd_w = '0;
  logic [8:0] cmd_y0 = '0, cmd_h = '0;
  logic [11:0] cmd_color = '0;
  logic cmd_ready, wr_en, busy, done;
  logic [18:0] wr_addr;
  logic [11:0] wr_data;
  int tests = 0, fails = 0;
  int pat [6] = '{1, 0, 0, 1, 1, 1};
`ifdef FILL_VBLANK_ONLY_EN
  localparam bit GATE = 1'b1;
`else
  localparam bit GATE = 1'b0;
`endif
  typedef struct {
    int x0, y0, w, h;
    logic [11:0] col;
    int n, dcyc;
    logic [18:0] fa, la;
  } vec_t;

  fb_rect_fill dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_x0(cmd_x0), .cmd_y0(cmd_y0), .cmd_w(cmd_w), .cmd_h(cmd_h),
    .cmd_color(cmd_color), .vblank(vblank), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic send(input logic [9:0] x0, input logic [8:0] y0, input logic [9:0] w,
                      input logic [8:0] h, input logic [11:0] col);
    int t;
    t = 0;
    @(negedge clk);
    while (!cmd_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk("ready_before_cmd", {31'd0, cmd_ready}, 1);
    cmd_x0 = x0; cmd_y0 = y0; cmd_w = w; cmd_h = h; cmd_color = col;
    cmd_valid = 1'b1;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    cmd_x0 = 10'($urandom); cmd_y0 = 9'($urandom); cmd_w = 10'($urandom);
    cmd_h = 9'($urandom); cmd_color = 12'($urandom);
  endtask

  // mode: 0 vblank high, 1 random vblank, 2 vblank from pat[] starting in cycle 2
  task automatic do_cmd(input int x0, input int y0, input int w, input int h, input logic [11:0] col,
                        input int mode, output int n_wr, output logic [18:0] fa, output logic [18:0] la,
                        output int dcyc);
    logic [18:0] q[$];
    int xe, ye, idx, n;
    bit done_seen, fin, g;
    q = {};
    xe = (x0 + w > 640) ? 640 : x0 + w;
    ye = (y0 + h > 480) ? 480 : y0 + h;
    for (int y = y0; y < ye; y++)
      for (int x = x0; x < xe; x++) q.push_back({10'(x), 9'(y)});
    n = q.size();
    idx = 0; n_wr = 0; fa = '0; la = '0; dcyc = 0; done_seen = 0; fin = 0;
    send(10'(x0), 9'(y0), 10'(w), 9'(h), col);
    for (int c = 1; c <= 6 * n + 100 && !fin; c++) begin
      if (mode == 0) vblank = 1'b1;
      else if (mode == 1) vblank = 1'($urandom);
      else vblank = (c >= 2 && c < 8) ? 1'(pat[c-2]) : 1'b1;
      @(negedge clk);
      if (wr_en) begin
        if (n_wr == 0) fa = wr_addr;
        la = wr_addr;
        n_wr++;
      end
      if (c == 1) begin
        chk("clip_wr_en", {31'd0, wr_en}, 0);
        chk("clip_done", {31'd0, done}, 0);
        chk("clip_ready", {31'd0, cmd_ready}, 0);
        chk("clip_busy", {31'd0, busy}, 1);
      end else if (idx < n) begin
        g = GATE ? vblank : 1'b1;
        chk("fill_wr_en", {31'd0, wr_en}, {31'd0, g});
        if (g) begin
          chk($sformatf("fill_addr[%0d]", idx), {13'd0, wr_addr}, {13'd0, q[idx]});
          chk("fill_data", {20'd0, wr_data}, {20'd0, col});
          idx++;
        end
        chk("fill_done", {31'd0, done}, 0);
        chk("fill_ready", {31'd0, cmd_ready}, 0);
      end else if (!done_seen) begin
        chk("done_pulse", {31'd0, done}, 1);
        chk("done_wr_en", {31'd0, wr_en}, 0);
        chk("done_ready", {31'd0, cmd_ready}, 0);
        chk("done_busy", {31'd0, busy}, 1);
        done_seen = 1;
        dcyc = c;
      end else begin
        chk("ready_back", {31'd0, cmd_ready}, 1);
        chk("idle_busy", {31'd0, busy}, 0);
        chk("idle_done", {31'd0, done}, 0);
        fin = 1;
      end
      if (!fin) begin
        @(posedge clk);
        #1;
      end
    end
    chk("cmd_timeout", {31'd0, fin}, 1);
  endtask

  initial begin : main
    vec_t tbl [9];
    int n, dc, hs, rf, t;
    bit hn;
    logic [18:0] fa, la;
    logic [30:0] wq[$], eq[$];
    repeat (2) @(negedge clk);
    chk("rst_ready", {31'd0, cmd_ready}, 0);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_done", {31'd0, done}, 0);
    chk("rst_wr_en", {31'd0, wr_en}, 0);
    chk("rst_addr", {13'd0, wr_addr}, 0);
    chk("rst_data", {20'd0, wr_data}, 0);
    reset = 1'b0;
    #1;
    chk("rst_release_ready", {31'd0, cmd_ready}, 1);

    tbl[0] = '{10, 20, 2, 2, 12'hF00, 4, 6, {10'd10, 9'd20}, {10'd11, 9'd21}};
    tbl[1] = '{638, 479, 10, 5, 12'h0AB, 2, 4, {10'd638, 9'd479}, {10'd639, 9'd479}};
    tbl[2] = '{5, 5, 0, 3, 12'h123, 0, 2, 19'd0, 19'd0};
    tbl[3] = '{700, 5, 4, 4, 12'h456, 0, 2, 19'd0, 19'd0};
    tbl[4] = '{5, 480, 4, 4, 12'h789, 0, 2, 19'd0, 19'd0};
    tbl[5] = '{7, 9, 3, 0, 12'hABC, 0, 2, 19'd0, 19'd0};
    tbl[6] = '{639, 0, 1, 1, 12'hFFF, 1, 3, {10'd639, 9'd0}, {10'd639, 9'd0}};
    tbl[7] = '{0, 100, 640, 1, 12'h5A5, 640, 642, {10'd0, 9'd100}, {10'd639, 9'd100}};
    tbl[8] = '{630, 470, 20, 20, 12'h3C3, 100, 102, {10'd630, 9'd470}, {10'd639, 9'd479}};
    for (int i = 0; i < 9; i++) begin
      do_cmd(tbl[i].x0, tbl[i].y0, tbl[i].w, tbl[i].h, tbl[i].col, 0, n, fa, la, dc);
      chk($sformatf("vec%0d_count", i), n, tbl[i].n);
      chk($sformatf("vec%0d_done_cycle", i), dc, tbl[i].dcyc);
      chk($sformatf("vec%0d_first", i), {13'd0, fa}, {13'd0, tbl[i].fa});
      chk($sformatf("vec%0d_last", i), {13'd0, la}, {13'd0, tbl[i].la});
    end

    // back-to-back: second command held valid while the first 3x1 fill runs
    vblank = 1'b1;
    @(negedge clk);
    t = 0;
    while (!cmd_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    cmd_x0 = 10'd20; cmd_y0 = 9'd7; cmd_w = 10'd3; cmd_h = 9'd1; cmd_color = 12'h00F;
    cmd_valid = 1'b1;
    @(posedge clk);
    #1;
    cmd_x0 = 10'd5; cmd_y0 = 9'd6; cmd_w = 10'd2; cmd_h = 9'd2; cmd_color = 12'h0F0;
    hs = 0; rf = 0; wq = {};
    for (int c = 1; c <= 30; c++) begin
      @(negedge clk);
      if (wr_en) wq.push_back({wr_addr, wr_data});
      if (cmd_ready && rf == 0) rf = c;
      hn = cmd_valid && cmd_ready;
      if (hn) hs++;
      @(posedge clk);
      #1;
      if (hn) cmd_valid = 1'b0;
    end
    eq = '{{10'd20, 9'd7, 12'h00F}, {10'd21, 9'd7, 12'h00F}, {10'd22, 9'd7, 12'h00F},
           {10'd5, 9'd6, 12'h0F0}, {10'd6, 9'd6, 12'h0F0}, {10'd5, 9'd7, 12'h0F0}, {10'd6, 9'd7, 12'h0F0}};
    chk("b2b_ready_cycle", rf, 6);
    chk("b2b_second_accepts", hs, 1);
    chk("b2b_write_count", wq.size(), 7);
    for (int i = 0; i < 7 && i < wq.size(); i++)
      chk($sformatf("b2b_write[%0d]", i), {1'b0, wq[i]}, {1'b0, eq[i]});

    // reset during the 5th pixel of a 4x4 fill
    vblank = 1'b1;
    send(10'd100, 9'd50, 10'd4, 9'd4, 12'h0A5);
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      if (c < 6) begin
        @(posedge clk);
        #1;
      end
    end
    chk("midrst_pre_wr_en", {31'd0, wr_en}, 1);
    chk("midrst_pre_addr", {13'd0, wr_addr}, {13'd0, 10'd100, 9'd51});
    reset = 1'b1;
    #1;
    chk("midrst_wr_en", {31'd0, wr_en}, 0);
    chk("midrst_ready", {31'd0, cmd_ready}, 0);
    chk("midrst_busy", {31'd0, busy}, 0);
    chk("midrst_done", {31'd0, done}, 0);
    chk("midrst_addr", {13'd0, wr_addr}, 0);
    chk("midrst_data", {20'd0, wr_data}, 0);
    @(posedge clk);
    @(negedge clk);
    chk("midrst_no_done", {31'd0, done}, 0);
    chk("midrst_still_idle", {31'd0, busy}, 0);
    reset = 1'b0;
    #1;
    chk("midrst_release_ready", {31'd0, cmd_ready}, 1);
    do_cmd(10, 20, 2, 2, 12'hF00, 0, n, fa, la, dc);
    chk("post_rst_count", n, 4);
    chk("post_rst_done_cycle", dc, 6);
    chk("post_rst_first", {13'd0, fa}, {13'd0, 10'd10, 9'd20});

`ifdef FILL_VBLANK_ONLY_EN
    do_cmd(50, 60, 4, 1, 12'h777, 2, n, fa, la, dc);
    chk("vb_count", n, 4);
    chk("vb_done_cycle", dc, 8);
    chk("vb_first", {13'd0, fa}, {13'd0, 10'd50, 9'd60});
    chk("vb_last", {13'd0, la}, {13'd0, 10'd53, 9'd60});
`endif

    for (int i = 0; i < 40; i++) begin
      do_cmd(($urandom % 8 == 0) ? 600 + int'($urandom % 100) : int'($urandom % 640),
             ($urandom % 8 == 0) ? 440 + int'($urandom % 60) : int'($urandom % 480),
             int'($urandom % 20), int'($urandom % 6), 12'($urandom), 1, n, fa, la, dc);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, %0d tests run, %0d failed", tests, fails);
    $fatal(1);
  end
endmodule
